// File: rtl/finish_grant_tracker.sv
// -----------------------------------------------------------------------------
// finish_grant_tracker
//
// Sits between the outer Grant channel and the client-side Grant port, just
// upstream of the 2-entry finish queue. Grant beats pass straight through with
// zero latency. Beats of multibeat grants are counted. Every grant that needs
// an acknowledgement produces exactly one Finish (manager_xact_id, manager_id)
// on its last beat. That Finish is held in a 1-entry register and offered on
// the finish enqueue interface.
//
// Optional feature (compile-time macro GRANT_BEAT_CHECK_EN):
//   When defined, each multibeat beat's addr_beat is compared against the
//   internal beat counter, and any mismatch sets the sticky io_err flag.
//   When undefined, no comparator is built and io_err is tied low.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   io_gin_*                   outer Grant channel (valid/ready + bits)
//   io_gout_*                  client Grant channel (valid/ready + bits)
//   io_fin_*                   Finish enqueue interface (valid/ready + ids)
//   io_beat                    current beat counter
//   io_err                     sticky beat-order error
// -----------------------------------------------------------------------------
module finish_grant_tracker #(
  parameter int BEATS  = 4,
  parameter int DATA_W = 64,
  localparam int BW    = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              io_gin_ready,
  input  logic              io_gin_valid,
  input  logic              io_gin_bits_is_builtin,
  input  logic [3:0]        io_gin_bits_g_type,
  input  logic [BW-1:0]     io_gin_bits_addr_beat,
  input  logic [1:0]        io_gin_bits_client_xact_id,
  input  logic [1:0]        io_gin_bits_manager_xact_id,
  input  logic              io_gin_bits_manager_id,
  input  logic [DATA_W-1:0] io_gin_bits_data,
  input  logic              io_gout_ready,
  output logic              io_gout_valid,
  output logic              io_gout_bits_is_builtin,
  output logic [3:0]        io_gout_bits_g_type,
  output logic [BW-1:0]     io_gout_bits_addr_beat,
  output logic [1:0]        io_gout_bits_client_xact_id,
  output logic [1:0]        io_gout_bits_manager_xact_id,
  output logic              io_gout_bits_manager_id,
  output logic [DATA_W-1:0] io_gout_bits_data,
  input  logic              io_fin_ready,
  output logic              io_fin_valid,
  output logic [1:0]        io_fin_bits_manager_xact_id,
  output logic              io_fin_bits_manager_id,
  output logic [BW-1:0]     io_beat,
  output logic              io_err
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [BW-1:0] beat_cnt_r;
  logic          fin_pending_r;
  logic [1:0]    fin_xact_r;
  logic          fin_mgr_r;

  logic multibeat_s;
  logic needs_ack_s;
  logic last_beat_s;
  logic fin_stall_s;
  logic g_fire_s;
  logic fin_load_s;
  logic fin_drain_s;

  // Grant decode and handshake qualification
  always_comb begin
    multibeat_s = 1'b0;
    needs_ack_s = 1'b1;
    if (io_gin_bits_is_builtin) begin
      multibeat_s = (io_gin_bits_g_type == 4'd4);
      needs_ack_s = (io_gin_bits_g_type != 4'd0);
    end else begin
      multibeat_s = (io_gin_bits_g_type < 4'd2);
      needs_ack_s = 1'b1;
    end
    last_beat_s = !multibeat_s || (beat_cnt_r == LAST_BEAT);
    // Only a beat that would load a new Finish stalls, and only when the
    // holding register is occupied and cannot drain this cycle.
    fin_stall_s = needs_ack_s && last_beat_s && fin_pending_r && !io_fin_ready;
    g_fire_s    = io_gin_valid && io_gin_ready;
    fin_load_s  = g_fire_s && needs_ack_s && last_beat_s;
    fin_drain_s = fin_pending_r && io_fin_ready;
  end

  // Zero-latency Grant pass-through
  always_comb begin
    io_gin_ready                 = io_gout_ready && !fin_stall_s;
    io_gout_valid                = io_gin_valid && !fin_stall_s;
    io_gout_bits_is_builtin      = io_gin_bits_is_builtin;
    io_gout_bits_g_type          = io_gin_bits_g_type;
    io_gout_bits_addr_beat       = io_gin_bits_addr_beat;
    io_gout_bits_client_xact_id  = io_gin_bits_client_xact_id;
    io_gout_bits_manager_xact_id = io_gin_bits_manager_xact_id;
    io_gout_bits_manager_id      = io_gin_bits_manager_id;
    io_gout_bits_data            = io_gin_bits_data;
  end

  // Beat counter; power-of-two BEATS makes the natural wrap the modulo wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_r <= '0;
    end else if (g_fire_s && multibeat_s) begin
      beat_cnt_r <= beat_cnt_r + BW'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Finish holding register; a same-cycle load overrides the drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fin_pending_r <= 1'b0;
      fin_xact_r    <= 2'd0;
      fin_mgr_r     <= 1'b0;
    end else if (fin_load_s) begin
      fin_pending_r <= 1'b1;
      fin_xact_r    <= io_gin_bits_manager_xact_id;
      fin_mgr_r     <= io_gin_bits_manager_id;
    end else if (fin_drain_s) begin
      fin_pending_r <= 1'b0;
    end else begin
      fin_pending_r <= fin_pending_r;
    end
  end

  assign io_fin_valid                = fin_pending_r;
  assign io_fin_bits_manager_xact_id = fin_xact_r;
  assign io_fin_bits_manager_id      = fin_mgr_r;
  assign io_beat                     = beat_cnt_r;

`ifdef GRANT_BEAT_CHECK_EN
  logic err_r;

  // Sticky beat-order error: addr_beat must track the internal counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (g_fire_s && multibeat_s && (io_gin_bits_addr_beat != beat_cnt_r)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign io_err = err_r;
`else
  assign io_err = 1'b0;
`endif

endmodule

// File: tb/tb_finish_grant_tracker.sv
module tb_finish_grant_tracker;

  localparam int BEATS  = 4;
  localparam int DATA_W = 64;
  localparam int BW     = 2;

`ifdef GRANT_BEAT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              io_gin_ready;
  logic              io_gin_valid;
  logic              io_gin_bits_is_builtin;
  logic [3:0]        io_gin_bits_g_type;
  logic [BW-1:0]     io_gin_bits_addr_beat;
  logic [1:0]        io_gin_bits_client_xact_id;
  logic [1:0]        io_gin_bits_manager_xact_id;
  logic              io_gin_bits_manager_id;
  logic [DATA_W-1:0] io_gin_bits_data;
  logic              io_gout_ready;
  logic              io_gout_valid;
  logic              io_gout_bits_is_builtin;
  logic [3:0]        io_gout_bits_g_type;
  logic [BW-1:0]     io_gout_bits_addr_beat;
  logic [1:0]        io_gout_bits_client_xact_id;
  logic [1:0]        io_gout_bits_manager_xact_id;
  logic              io_gout_bits_manager_id;
  logic [DATA_W-1:0] io_gout_bits_data;
  logic              io_fin_ready;
  logic              io_fin_valid;
  logic [1:0]        io_fin_bits_manager_xact_id;
  logic              io_fin_bits_manager_id;
  logic [BW-1:0]     io_beat;
  logic              io_err;

  int checks = 0;
  int errors = 0;

  finish_grant_tracker #(.BEATS(BEATS), .DATA_W(DATA_W)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .io_gin_ready                 (io_gin_ready),
    .io_gin_valid                 (io_gin_valid),
    .io_gin_bits_is_builtin       (io_gin_bits_is_builtin),
    .io_gin_bits_g_type           (io_gin_bits_g_type),
    .io_gin_bits_addr_beat        (io_gin_bits_addr_beat),
    .io_gin_bits_client_xact_id   (io_gin_bits_client_xact_id),
    .io_gin_bits_manager_xact_id  (io_gin_bits_manager_xact_id),
    .io_gin_bits_manager_id       (io_gin_bits_manager_id),
    .io_gin_bits_data             (io_gin_bits_data),
    .io_gout_ready                (io_gout_ready),
    .io_gout_valid                (io_gout_valid),
    .io_gout_bits_is_builtin      (io_gout_bits_is_builtin),
    .io_gout_bits_g_type          (io_gout_bits_g_type),
    .io_gout_bits_addr_beat       (io_gout_bits_addr_beat),
    .io_gout_bits_client_xact_id  (io_gout_bits_client_xact_id),
    .io_gout_bits_manager_xact_id (io_gout_bits_manager_xact_id),
    .io_gout_bits_manager_id      (io_gout_bits_manager_id),
    .io_gout_bits_data            (io_gout_bits_data),
    .io_fin_ready                 (io_fin_ready),
    .io_fin_valid                 (io_fin_valid),
    .io_fin_bits_manager_xact_id  (io_fin_bits_manager_xact_id),
    .io_fin_bits_manager_id       (io_fin_bits_manager_id),
    .io_beat                      (io_beat),
    .io_err                       (io_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic bi, input logic [3:0] gt,
                       input logic [1:0] ab, input logic [1:0] mx, input logic mi,
                       input logic [63:0] d);
    io_gin_valid                = v;
    io_gin_bits_is_builtin      = bi;
    io_gin_bits_g_type          = gt;
    io_gin_bits_addr_beat       = ab;
    io_gin_bits_client_xact_id  = 2'd1;
    io_gin_bits_manager_xact_id = mx;
    io_gin_bits_manager_id      = mi;
    io_gin_bits_data            = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 4'd3, 2'd0, 2'd0, 1'b0, 64'd0);
  endtask

  initial begin
    reset         = 1'b0;
    io_gout_ready = 1'b1;
    io_fin_ready  = 1'b1;
    idle();
    tick();
    chk("rst_fin_valid", io_fin_valid, 1'b0);
    chk("rst_beat", io_beat, 2'd0);
    chk("rst_err", io_err, 1'b0);
    reset = 1'b1;
    tick();
    chk("idle_fin_valid", io_fin_valid, 1'b0);
    chk("idle_gout_valid", io_gout_valid, 1'b0);
    chk("idle_beat", io_beat, 2'd0);
    chk("idle_err", io_err, 1'b0);

    // Single-beat acked grant (non-builtin type 2)
    drive(1'b1, 1'b0, 4'd2, 2'd0, 2'b10, 1'b1, 64'hDEAD_BEEF_0123_4567);
    chk("sb_gout_valid", io_gout_valid, 1'b1);
    chk("sb_gin_ready", io_gin_ready, 1'b1);
    chk("sb_gout_data", io_gout_bits_data, 64'hDEAD_BEEF_0123_4567);
    chk("sb_gout_xact", io_gout_bits_manager_xact_id, 2'b10);
    chk("sb_gout_gtype", io_gout_bits_g_type, 4'd2);
    chk("sb_gout_cxact", io_gout_bits_client_xact_id, 2'd1);
    chk("sb_fin_before", io_fin_valid, 1'b0);
    tick();
    idle();
    chk("sb_fin_valid", io_fin_valid, 1'b1);
    chk("sb_fin_xact", io_fin_bits_manager_xact_id, 2'b10);
    chk("sb_fin_mgr", io_fin_bits_manager_id, 1'b1);
    chk("sb_beat", io_beat, 2'd0);
    tick();
    chk("sb_fin_clear", io_fin_valid, 1'b0);

    // Builtin type 4: four back-to-back beats, one Finish after beat 3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'd4, 2'(i), 2'd1, 1'b0, 64'(i) + 64'h100);
      chk("mb_beat", io_beat, 64'(i));
      chk("mb_fin_quiet", io_fin_valid, 1'b0);
      chk("mb_gout_data", io_gout_bits_data, 64'(i) + 64'h100);
      tick();
    end
    idle();
    chk("mb_beat_wrap", io_beat, 2'd0);
    chk("mb_fin_valid", io_fin_valid, 1'b1);
    chk("mb_fin_xact", io_fin_bits_manager_xact_id, 2'd1);
    chk("mb_fin_mgr", io_fin_bits_manager_id, 1'b0);
    chk("mb_err", io_err, 1'b0);
    tick();
    chk("mb_fin_once", io_fin_valid, 1'b0);

    // Builtin type 0: voluntary ack, forwarded but no Finish
    drive(1'b1, 1'b1, 4'd0, 2'd0, 2'd3, 1'b1, 64'h55);
    chk("va_gout_valid", io_gout_valid, 1'b1);
    tick();
    idle();
    chk("va_no_fin", io_fin_valid, 1'b0);
    chk("va_beat", io_beat, 2'd0);
    tick();
    chk("va_no_fin2", io_fin_valid, 1'b0);

    // Back-pressure: Finish held, second acked grant stalls
    io_fin_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd3, 2'd0, 2'd1, 1'b1, 64'h1);
    tick();
    drive(1'b1, 1'b0, 4'd2, 2'd0, 2'd2, 1'b0, 64'h2);
    chk("bp_gin_ready", io_gin_ready, 1'b0);
    chk("bp_gout_valid", io_gout_valid, 1'b0);
    chk("bp_fin_valid", io_fin_valid, 1'b1);
    chk("bp_fin_xact", io_fin_bits_manager_xact_id, 2'd1);
    tick();
    chk("bp_hold_ready", io_gin_ready, 1'b0);
    chk("bp_stable_xact", io_fin_bits_manager_xact_id, 2'd1);
    chk("bp_stable_mgr", io_fin_bits_manager_id, 1'b1);
    // Non-last beat and no-ack grant still flow while full (not clocked in)
    drive(1'b1, 1'b1, 4'd4, 2'd0, 2'd0, 1'b0, 64'h3);
    chk("bp_nonlast_ready", io_gin_ready, 1'b1);
    drive(1'b1, 1'b1, 4'd0, 2'd0, 2'd0, 1'b0, 64'h4);
    chk("bp_noack_ready", io_gin_ready, 1'b1);
    drive(1'b1, 1'b0, 4'd2, 2'd0, 2'd2, 1'b0, 64'h2);
    io_fin_ready = 1'b1;
    #1;
    chk("bp_release_ready", io_gin_ready, 1'b1);
    chk("bp_release_valid", io_gout_valid, 1'b1);
    tick();
    idle();
    chk("bp_swap_valid", io_fin_valid, 1'b1);
    chk("bp_swap_xact", io_fin_bits_manager_xact_id, 2'd2);
    chk("bp_swap_mgr", io_fin_bits_manager_id, 1'b0);
    tick();
    chk("bp_drained", io_fin_valid, 1'b0);

    // Beat-order check: addr_beat 0 then 2
    drive(1'b1, 1'b1, 4'd4, 2'd0, 2'd0, 1'b0, 64'h10);
    tick();
    chk("bo_err_beat0", io_err, 1'b0);
    drive(1'b1, 1'b1, 4'd4, 2'd2, 2'd0, 1'b0, 64'h12);
    chk("bo_data_pass", io_gout_bits_addr_beat, 2'd2);
    tick();
    idle();
    chk("bo_err_set", io_err, ERR_EXP);
    chk("bo_beat", io_beat, 2'd2);
    tick();
    chk("bo_err_sticky", io_err, ERR_EXP);

    // Reset mid-burst discards counter and error
    reset = 1'b0;
    #1;
    chk("mr_beat", io_beat, 2'd0);
    chk("mr_err", io_err, 1'b0);
    chk("mr_fin", io_fin_valid, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'd4, 2'd0, 2'd0, 1'b0, 64'h20);
    tick();
    idle();
    chk("mr_next_beat", io_beat, 2'd1);
    chk("mr_next_err", io_err, 1'b0);
    chk("mr_no_fin", io_fin_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
